// File: rtl/exercise_1.sv
// Selectable unsigned divider: picks one of four operand pairings, divides
// with an explicit restoring array, and registers quotient and divide-by-zero flag.
module exercise_1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] out,
  output logic             error
);

  localparam int unsigned REM_W = WIDTH + 1;

  logic [WIDTH-1:0] dividend_c;
  logic [WIDTH-1:0] divisor_c;
  logic [WIDTH-1:0] quot_c;
  logic [REM_W-1:0] rem_c;
  logic [REM_W-1:0] diff_c;
  logic             div_zero_c;

  logic [WIDTH-1:0] out_d, out_q;
  logic             error_d, error_q;

  // Operand pairing: dividend/divisor chosen by select.
  always_comb begin
    dividend_c = A;
    divisor_c  = B;
    case (select)
      2'b00: begin dividend_c = A; divisor_c = B; end
      2'b01: begin dividend_c = B; divisor_c = C; end
      2'b10: begin dividend_c = C; divisor_c = D; end
      default: begin dividend_c = D; divisor_c = A; end
    endcase
  end

  // Restoring array: each stage shifts in one dividend bit, trial-subtracts
  // the divisor and keeps the difference when no borrow occurs.
  always_comb begin
    rem_c  = '0;
    diff_c = '0;
    quot_c = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      rem_c  = {rem_c[WIDTH-1:0], dividend_c[i]};
      diff_c = rem_c - {1'b0, divisor_c};
      if (!diff_c[WIDTH]) begin
        rem_c     = diff_c;
        quot_c[i] = 1'b1;
      end
    end
  end

  // Result selection: a zero divisor forces all ones and raises the flag.
  always_comb begin
    div_zero_c = (divisor_c == '0);
    error_d    = div_zero_c;
    out_d      = div_zero_c ? '1 : quot_c;
  end

  // Output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      error_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      error_q <= error_d;
    end
  end

  assign out   = out_q;
  assign error = error_q;

endmodule

// File: tb/tb_exercise_1.sv
// Self-checking bench for exercise_1: directed cases plus randomized
// back-to-back operations against an arithmetic reference model.
module tb_exercise_1;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] A, B, C, D;
  logic [1:0]       select;
  logic [WIDTH-1:0] out;
  logic             error;

  int total;
  int bad;

  exercise_1 #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .select (select),
    .out    (out),
    .error  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain unsigned division of the pairing named by select.
  task automatic model(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d,
                       output logic [7:0] q, output logic e);
    int unsigned num, den;
    case (sel)
      2'd0: begin num = a; den = b; end
      2'd1: begin num = b; den = c; end
      2'd2: begin num = c; den = d; end
      default: begin num = d; den = a; end
    endcase
    if (den == 0) begin
      q = 8'hFF;
      e = 1'b1;
    end else begin
      q = 8'(num / den);
      e = 1'b0;
    end
  endtask

  // Present one operation, then check the result one edge later.
  task automatic apply(input string tag, input logic [1:0] sel, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    logic [7:0] q;
    logic       e;
    @(negedge clk);
    select = sel; A = a; B = b; C = c; D = d;
    model(sel, a, b, c, d, q, e);
    @(posedge clk);
    #1;
    check({tag, ".out"}, 32'(out), 32'(q));
    check({tag, ".err"}, 32'(error), 32'(e));
  endtask

  // Directed expectation taken straight from hand-computed values.
  task automatic apply_exp(input string tag, input logic [1:0] sel, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                           input logic [7:0] q, input logic e);
    @(negedge clk);
    select = sel; A = a; B = b; C = c; D = d;
    @(posedge clk);
    #1;
    check({tag, ".out"}, 32'(out), 32'(q));
    check({tag, ".err"}, 32'(error), 32'(e));
  endtask

  initial begin
    logic [7:0] ra, rb, rc, rd;
    logic [1:0] rs;
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    select = 2'b11; A = 8'h00; B = 8'h33; C = 8'h44; D = 8'h00;

    // Asynchronous reset with arbitrary inputs, held across a clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_async.out", 32'(out), 32'd0);
    check("rst_async.err", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold.out", 32'(out), 32'd0);
    check("rst_hold.err", 32'(error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release captures the presented div-by-zero case.
    @(posedge clk);
    #1;
    check("rst_rel.out", 32'(out), 32'hFF);
    check("rst_rel.err", 32'(error), 32'd1);

    apply_exp("s0_15_2",   2'd0, 8'd15,  8'd2,   8'd9,   8'd9,  8'd7,   1'b0);
    apply_exp("s0_87_202", 2'd0, 8'd87,  8'd202, 8'd9,   8'd9,  8'd0,   1'b0);
    apply_exp("s1_252_12", 2'd1, 8'd5,   8'd252, 8'd12,  8'd9,  8'd21,  1'b0);
    apply_exp("s1_0_8",    2'd1, 8'd5,   8'd0,   8'd8,   8'd9,  8'd0,   1'b0);
    apply_exp("s2_128_12", 2'd2, 8'd5,   8'd5,   8'd128, 8'd12, 8'd10,  1'b0);
    apply_exp("s2_222_18", 2'd2, 8'd5,   8'd5,   8'd222, 8'd18, 8'd12,  1'b0);
    apply_exp("s3_12_0",   2'd3, 8'd0,   8'd5,   8'd5,   8'd12, 8'hFF,  1'b1);
    apply_exp("s3_0_0",    2'd3, 8'd0,   8'd5,   8'd5,   8'd0,  8'hFF,  1'b1);
    apply_exp("s0_255_1",  2'd0, 8'd255, 8'd1,   8'd0,   8'd0,  8'd255, 1'b0);
    apply_exp("s1_255_255",2'd1, 8'd0,   8'd255, 8'd255, 8'd0,  8'd1,   1'b0);
    apply_exp("s2_254_255",2'd2, 8'd0,   8'd0,   8'd254, 8'd255,8'd0,   1'b0);

    // Back-to-back random operations cycling through every select code.
    for (int i = 0; i < 400; i++) begin
      rs = 2'(i);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 8'($urandom);
      rd = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        case (rs)
          2'd0: rb = 8'd0;
          2'd1: rc = 8'd0;
          2'd2: rd = 8'd0;
          default: ra = 8'd0;
        endcase
      end
      if ($urandom_range(0, 3) == 0) rs = 2'($urandom);
      apply("rand", rs, ra, rb, rc, rd);
    end

    // Mid-stream reset: a flagged result must clear immediately.
    apply_exp("pre_rst", 2'd2, 8'd1, 8'd1, 8'd77, 8'd0, 8'hFF, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst.out", 32'(out), 32'd0);
    check("mid_rst.err", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_hold.out", 32'(out), 32'd0);
    check("mid_rst_hold.err", 32'(error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      apply("post_rst", 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exercise_1.md
Name: exercise_1

Overview:
- Selectable unsigned integer divider with divide-by-zero flag.
- A 2-bit select chooses one of four fixed operand pairings from four WIDTH-bit inputs. The block produces the truncated quotient and an error flag, both registered.
- Used as a small arithmetic leaf block; the consumer samples out/error one clock after the operands and select are presented.

Parameters:
- WIDTH, 8, bit width of every data operand and of the quotient.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- C  input  WIDTH  operand C.
- D  input  WIDTH  operand D.
- select  input  2  operand-pair select.
- out  output  WIDTH  registered quotient.
- error  output  1  registered divide-by-zero flag.

Behaviour:
- Clocking: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, out=0 and error=0 immediately, regardless of clk. The first capture after release happens on the first rising clk edge with rst_n=1.
- Operand selection (dividend / divisor):
  - select 00: A / B
  - select 01: B / C
  - select 10: C / D
  - select 11: D / A
- Arithmetic:
  - Unsigned, quotient truncated toward zero, result WIDTH bits; the remainder is discarded.
  - Quotient is always at most the dividend, so no overflow is possible.
- Divide by zero (selected divisor == 0): error=1 and out = all ones (8'hFF for WIDTH=8). Otherwise error=0.
- Dividend == 0 with nonzero divisor: out=0, error=0.
- Dividend < divisor: out=0, error=0.
- Latency: exactly 1 cycle. Inputs present at rising edge N produce out/error valid after edge N and held until edge N+1.
  - No handshake; a new operation is accepted every cycle (fully pipelined, throughput 1/cycle).
- Datapath:
  - Combinational restoring array divider (WIDTH stages of compare/subtract/shift), written explicitly; the HDL "/" operator is not used.
  - Operand mux feeds the array; outputs are registered.
- Select or operand change mid-cycle: only values stable at the rising edge matter; no glitch reaches out/error.
- Reset asserted mid-stream: out/error clear asynchronously; no pending result survives reset.
- No X propagation: out/error are never X after reset, including the divide-by-zero case.

Test Plan:
- Reset check: rst_n=0 with arbitrary inputs -> out=0, error=0 asynchronously. Release rst_n, then after one edge -> valid result.
- select=00, A=15, B=2 -> out=7, error=0. Then A=87, B=202 -> out=0, error=0.
- select=01, B=252, C=12 -> out=21, error=0. Then B=0, C=8 -> out=0, error=0 (zero dividend).
- select=10, C=128, D=12 -> out=10, error=0. Then C=222, D=18 -> out=12, error=0.
- select=11, A=0, D=12 -> out=8'hFF, error=1. Also select=11, A=0, D=0 -> out=8'hFF, error=1.
- Back-to-back: change select every cycle across all four codes with random operands. Each result must appear exactly one cycle later and match an unsigned-division reference model. Assert rst_n mid-sequence -> immediate clear.
